// File: rtl/resp_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : resp_mon_pkg - shared types, defaults and lane-fold helper
// Revision : 1.0
// ============================================================================
package resp_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int c_def_width = 17;
    localparam int c_def_lanes = 5;
    localparam int c_def_depth = 8;
    localparam logic [c_def_width-1:0] c_def_poly = 17'h12003;

    // The fold works on a fixed-size container so any WIDTH/LANES up to these limits can share it.
    localparam int c_fold_max_width = 32;
    localparam int c_fold_max_lanes = 16;
    localparam int c_fold_flat_w    = c_fold_max_width * c_fold_max_lanes;

    function automatic logic [c_fold_max_width-1:0] fold_lanes(
        input logic [c_fold_flat_w-1:0] flat,
        input int                       lanes,
        input int                       width
    );
        logic [c_fold_max_width-1:0] acc;
        acc = '0;
        for (int k = 0; k < c_fold_max_lanes; k++) begin
            for (int b = 0; b < c_fold_max_width; b++) begin
                if (k < lanes && b < width) begin
                    acc[b] = acc[b] ^ flat[k*width + b];
                end
            end
        end
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/resp_mon_fifo.sv
`default_nettype none
// ============================================================================
// Module   : resp_mon_fifo - synchronous FIFO with occupancy, flush, push+pop
// Revision : 1.0
// ============================================================================
module resp_mon_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        push_data,
    output logic [DATA_W-1:0]        head_data,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_aw = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_aw:0]     r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            r_count <= r_count + (c_aw+1)'(push) - (c_aw+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign valid = (r_count != '0);
    assign full  = (r_count == (c_aw+1)'(DEPTH));
    // Storage is not reset, so the head is masked to keep outputs at zero when empty.
    assign head_data = valid ? r_mem[r_rd_ptr] : '0;
    assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/resp_monitor.sv
`default_nettype none
// ============================================================================
// Module   : resp_monitor - lane capture FIFO, change flags, MISR signature
//            (MISR built only when RESP_MON_MISR_EN is defined)
// Revision : 1.0
// ============================================================================
module resp_monitor
    import resp_mon_pkg::*;
#(
    parameter int               WIDTH = c_def_width,
    parameter int               LANES = c_def_lanes,
    parameter int               DEPTH = c_def_depth,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(c_def_poly)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       arm_i,
    input  logic                       clear_i,
    input  logic                       sample_i,
    input  logic [LANES*WIDTH-1:0]     lane_i,
    output logic                       rd_valid_o,
    input  logic                       rd_ready_i,
    output logic [LANES*WIDTH-1:0]     rd_data_o,
    output logic [7:0]                 rd_idx_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [LANES-1:0]           change_o,
    output logic                       overflow_o,
    output logic [WIDTH-1:0]           sig_o,
    output logic [1:0]                 state_o
);

    localparam int c_lw = LANES * WIDTH;

    state_t           r_state;
    logic [7:0]       r_idx;
    logic [c_lw-1:0]  r_prev;
    logic [LANES-1:0] r_change;
    logic             r_overflow;

    logic             w_full;
    logic             w_pop;
    logic             w_live;
    logic             w_accept;
    logic             w_drop;
    logic [LANES-1:0] w_diff;
    logic [c_lw+7:0]  w_head;

    assign w_pop    = rd_valid_o && rd_ready_i;
    assign w_live   = (r_state == ST_RUN) && sample_i && !clear_i;
    // A full FIFO still takes a sample when the head leaves in the same cycle.
    assign w_accept = w_live && (!w_full || w_pop);
    assign w_drop   = w_live && w_full && !w_pop;

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_change
            assign w_diff[k] = (lane_i[k*WIDTH +: WIDTH] != r_prev[k*WIDTH +: WIDTH]);
        end
    endgenerate

    resp_mon_fifo #(
        .DATA_W (c_lw + 8),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear_i),
        .push      (w_accept),
        .pop       (w_pop),
        .push_data ({r_idx, lane_i}),
        .head_data (w_head),
        .valid     (rd_valid_o),
        .full      (w_full),
        .count     (count_o)
    );

    assign {rd_idx_o, rd_data_o} = w_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_prev     <= '0;
            r_change   <= '0;
            r_overflow <= 1'b0;
        end else if (clear_i) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_prev     <= '0;
            r_change   <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (arm_i)  r_state <= ST_RUN;
                ST_RUN:  if (w_drop) r_state <= ST_HOLD;
                ST_HOLD: r_state <= ST_HOLD;
                default: r_state <= ST_IDLE;
            endcase
            if (w_accept) begin
                r_idx    <= r_idx + 8'd1;
                r_prev   <= lane_i;
                r_change <= w_diff;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign change_o   = r_change;
    assign overflow_o = r_overflow;
    assign state_o    = r_state;

`ifdef RESP_MON_MISR_EN
    logic [WIDTH-1:0] r_sig;
    logic [WIDTH-1:0] w_fold;

    assign w_fold = WIDTH'(fold_lanes(c_fold_flat_w'(lane_i), LANES, WIDTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= '0;
        end else if (clear_i) begin
            r_sig <= '0;
        end else if (w_accept) begin
            r_sig <= {r_sig[WIDTH-2:0], 1'b0} ^ (r_sig[WIDTH-1] ? POLY : '0) ^ w_fold;
        end
    end

    assign sig_o = r_sig;
`else
    logic w_unused_poly;
    assign w_unused_poly = ^POLY;
    assign sig_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_resp_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_resp_monitor - scoreboard bench for resp_monitor
// Revision : 1.0
// ============================================================================
module tb_resp_monitor;

    localparam int               WIDTH = 17;
    localparam int               LANES = 5;
    localparam int               DEPTH = 8;
    localparam logic [WIDTH-1:0] POLY  = 17'h12003;
    localparam int               LW    = WIDTH * LANES;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          arm_i = 1'b0;
    logic          clear_i = 1'b0;
    logic          sample_i = 1'b0;
    logic          rd_ready_i = 1'b0;
    logic [LW-1:0] lane_i = '0;

    logic             rd_valid_o;
    logic [LW-1:0]    rd_data_o;
    logic [7:0]       rd_idx_o;
    logic [3:0]       count_o;
    logic [LANES-1:0] change_o;
    logic             overflow_o;
    logic [WIDTH-1:0] sig_o;
    logic [1:0]       state_o;

    resp_monitor #(
        .WIDTH (WIDTH),
        .LANES (LANES),
        .DEPTH (DEPTH),
        .POLY  (POLY)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .arm_i      (arm_i),
        .clear_i    (clear_i),
        .sample_i   (sample_i),
        .lane_i     (lane_i),
        .rd_valid_o (rd_valid_o),
        .rd_ready_i (rd_ready_i),
        .rd_data_o  (rd_data_o),
        .rd_idx_o   (rd_idx_o),
        .count_o    (count_o),
        .change_o   (change_o),
        .overflow_o (overflow_o),
        .sig_o      (sig_o),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    // Reference model: captures waiting for readout, plus the status the spec defines.
    logic [LW+7:0]    exp_q[$];
    int               m_state;
    int               m_idx;
    logic [LW-1:0]    m_prev;
    logic [LANES-1:0] m_change;
    logic             m_ovf;
    logic [WIDTH-1:0] m_sig;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [WIDTH-1:0] SIG_FF  = 17'h000FF;
    localparam logic [WIDTH-1:0] SIG_101 = 17'h00101;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_state  = 0;
        m_idx    = 0;
        m_prev   = '0;
        m_change = '0;
        m_ovf    = 1'b0;
        m_sig    = '0;
    endtask

    task automatic model_clock();
        logic [WIDTH-1:0] ln;
        if (clear_i) begin
            model_reset();
        end else if (m_state == 1 && sample_i) begin
            if (exp_q.size() < DEPTH) begin
                exp_q.push_back({8'(m_idx), lane_i});
                for (int k = 0; k < LANES; k++) begin
                    ln = lane_i[k*WIDTH +: WIDTH];
                    m_change[k] = (ln != m_prev[k*WIDTH +: WIDTH]);
                end
`ifdef RESP_MON_MISR_EN
                begin : b_misr
                    logic [WIDTH-1:0] fold;
                    int s;
                    fold = '0;
                    for (int k = 0; k < LANES; k++) fold = fold ^ lane_i[k*WIDTH +: WIDTH];
                    s = int'(m_sig) * 2;
                    if (s >= (1 << WIDTH)) s = (s - (1 << WIDTH)) ^ int'(POLY);
                    m_sig = WIDTH'(s) ^ fold;
                end
`endif
                m_prev = lane_i;
                m_idx  = (m_idx + 1) % 256;
            end else begin
                m_ovf   = 1'b1;
                m_state = 2;
            end
        end else if (m_state == 0 && arm_i) begin
            m_state = 1;
        end
    endtask

    // Monitor: status every cycle, head against the scoreboard, pop on handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("count", count_o, exp_q.size());
            chk("state", state_o, m_state);
            chk("overflow", overflow_o, m_ovf);
            chk("change", change_o, m_change);
            chk("sig", sig_o, m_sig);
            chk("rd_valid", rd_valid_o, exp_q.size() != 0);
            if (rd_valid_o && exp_q.size() != 0) begin
                chk("head_idx_data", {rd_idx_o, rd_data_o}, exp_q[0]);
                if (rd_ready_i) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step(input logic a, input logic c, input logic s, input logic r,
                        input logic [LW-1:0] l);
        arm_i      = a;
        clear_i    = c;
        sample_i   = s;
        rd_ready_i = r;
        lane_i     = l;
        @(posedge clk);
        model_clock();
        #1;
    endtask

    function automatic logic [LW-1:0] rand_lanes(input logic [LW-1:0] prev);
        logic [LW-1:0] v;
        v = prev;
        for (int k = 0; k < LANES; k++) begin
            if ($urandom_range(2) != 0) v[k*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_count"}, count_o, 0);
        chk({tag, "_valid"}, rd_valid_o, 0);
        chk({tag, "_data"}, rd_data_o, 0);
        chk({tag, "_idx"}, rd_idx_o, 0);
        chk({tag, "_change"}, change_o, 0);
        chk({tag, "_ovf"}, overflow_o, 0);
        chk({tag, "_sig"}, sig_o, 0);
        chk({tag, "_state"}, state_o, 0);
    endtask

    logic [LW-1:0] lane0_ff;

    initial begin
        lane0_ff = '0;
        lane0_ff[WIDTH-1:0] = 17'h000FF;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // All-zero capture
        step(1, 0, 0, 0, '0);
        step(0, 0, 1, 0, '0);
        chk("t1_count", count_o, 1);
        chk("t1_idx", rd_idx_o, 0);
        chk("t1_sig", sig_o, 0);
        chk("t1_change", change_o, 0);
        step(0, 0, 0, 1, '0);
        step(0, 1, 0, 0, '0);

        // Two identical lane-0 samples
        step(1, 0, 0, 0, '0);
        step(0, 0, 1, 0, lane0_ff);
`ifdef RESP_MON_MISR_EN
        chk("t2_sig1", sig_o, SIG_FF);
`else
        chk("t2_sig1", sig_o, 0);
`endif
        chk("t2_change1", change_o, 5'b00001);
        step(0, 0, 1, 0, lane0_ff);
`ifdef RESP_MON_MISR_EN
        chk("t2_sig2", sig_o, SIG_101);
`else
        chk("t2_sig2", sig_o, 0);
`endif
        chk("t2_change2", change_o, 5'b00000);
        step(0, 1, 0, 0, '0);

        // Overflow into HOLD, then drain
        step(1, 0, 0, 0, '0);
        repeat (9) step(0, 0, 1, 0, rand_lanes(lane_i));
        chk("t3_count", count_o, 8);
        chk("t3_ovf", overflow_o, 1);
        chk("t3_state", state_o, 2);
        step(0, 0, 1, 0, rand_lanes(lane_i));
        chk("t3_hold_count", count_o, 8);
        repeat (10) step(0, 0, 0, 1, '0);
        chk("t3_drained", count_o, 0);
        chk("t3_still_hold", state_o, 2);
        step(0, 1, 0, 0, '0);
        chk("t3_clr_state", state_o, 0);
        chk("t3_clr_ovf", overflow_o, 0);

        // Full FIFO with simultaneous pop
        step(1, 0, 0, 0, '0);
        repeat (8) step(0, 0, 1, 0, rand_lanes(lane_i));
        step(0, 0, 1, 1, rand_lanes(lane_i));
        chk("t4_count", count_o, 8);
        chk("t4_ovf", overflow_o, 0);
        chk("t4_state", state_o, 1);

        // Clear beats sample and arm
        step(0, 1, 1, 0, rand_lanes(lane_i));
        chk("t5_state", state_o, 0);
        chk("t5_count", count_o, 0);
        chk("t5_sig", sig_o, 0);
        step(0, 0, 1, 0, rand_lanes(lane_i));
        chk("t5_ignored", count_o, 0);
        step(1, 1, 0, 0, '0);
        chk("t5_clr_arm", state_o, 0);
        step(1, 0, 1, 0, rand_lanes(lane_i));
        chk("t5_arm_sample_cnt", count_o, 0);
        chk("t5_arm_sample_st", state_o, 1);

        // Streaming long enough to wrap the capture index
        step(0, 1, 0, 0, '0);
        step(1, 0, 0, 0, '0);
        repeat (300) step(0, 0, 1, 1, rand_lanes(lane_i));

        // Randomized traffic
        repeat (1500) begin
            step($urandom_range(7) == 0, $urandom_range(49) == 0,
                 $urandom_range(9) < 7, $urandom_range(1) == 1, rand_lanes(lane_i));
        end

        // Asynchronous reset in the middle of a drain
        step(0, 1, 0, 0, '0);
        step(1, 0, 0, 0, '0);
        repeat (6) step(0, 0, 1, 0, rand_lanes(lane_i));
        repeat (2) step(0, 0, 0, 1, '0);
        arm_i = 1'b0; clear_i = 1'b0; sample_i = 1'b0; rd_ready_i = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 0, 0, 0, '0);
        repeat (3) step(0, 0, 1, 0, rand_lanes(lane_i));
        repeat (4) step(0, 0, 0, 1, '0);
        chk("post_rst_count", count_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
